// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared constants and FSM state encodings for the memory-mapped
//               serial port controller (bus addresses, status bit positions,
//               default baud divisor, RX/TX state types).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    // Bus addresses decoded by the CPU MEM stage
    localparam logic [15:0] c_UART_DATA_ADDR   = 16'hBF00;
    localparam logic [15:0] c_UART_STAT_ADDR   = 16'hBF01;

    // Status word bit positions
    localparam int          c_STAT_TX_READY    = 0;
    localparam int          c_STAT_RX_AVAIL    = 1;
    localparam int          c_STAT_OVERRUN     = 2;
    localparam int          c_STAT_FRAME_ERR   = 3;
    localparam int          c_STAT_COUNT_LSB   = 4;

    // 11.0592 MHz / 115200 baud
    localparam int          c_UART_DIV_DEFAULT = 96;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : 8-bit wide receive FIFO, 2**DEPTH_LOG2 entries, head visible
//               combinationally. A push while full is only performed when a
//               pop happens in the same cycle.
// Ports       : clk, rst (async, active-high)
//               push, pop, din[7:0]  - write / read requests and write data
//               dout[7:0]            - current head entry
//               full, empty, count   - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                  c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [7:0]            mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  w_wr;
    logic                  w_rd;

    // Count never exceeds the depth, so its MSB is set only when full
    assign full  = count_q[DEPTH_LOG2];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A simultaneous pop frees the head slot, so a push into a full FIFO is legal then
    assign w_wr = push & (~full | pop);
    assign w_rd = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        if (w_wr && !w_rd) begin
            count_d = count_q + c_CNT_ONE;
        end else if (w_rd && !w_wr) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl
// Description : Memory-mapped 8N1 serial port: receiver with 4-entry FIFO,
//               single-byte transmitter, sticky overrun / framing flags.
// Ports       : clk, rst (async, active-high)
//               rxd / txd            - serial in (async) / serial out
//               cs, we, re, addr     - bus select, strobes, 0=data 1=status
//               wdata[15:0]          - write data (bits 7:0 used)
//               rdata[15:0]          - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DIV        = c_UART_DIV_DEFAULT,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    input  logic        cs,
    input  logic        we,
    input  logic        re,
    input  logic        addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);

    localparam int                 c_CNT_W    = $clog2(DIV);
    localparam logic [c_CNT_W-1:0] c_FULL_BIT = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_BIT = c_CNT_W'(DIV / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_BIT = 3'd7;
    localparam logic [2:0]         c_BIT_ONE  = 3'd1;

    // ---------------- state ----------------
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e           rx_state_q, rx_state_d;
    logic [c_CNT_W-1:0]  rx_cnt_q,   rx_cnt_d;
    logic [2:0]          rx_bit_q,   rx_bit_d;
    logic [7:0]          rx_shift_q, rx_shift_d;
    tx_state_e           tx_state_q, tx_state_d;
    logic [c_CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
    logic [2:0]          tx_bit_q,   tx_bit_d;
    logic [7:0]          tx_shift_q, tx_shift_d;
    logic                txd_q,      txd_d;
    logic                overrun_q,  overrun_d;
    logic                frame_err_q, frame_err_d;

    // ---------------- combinational ----------------
    logic                w_rx_fall;
    logic                w_rx_push;
    logic                w_frame_set;
    logic                w_ovr_set;
    logic                w_pop;
    logic                w_stat_rd;
    logic                w_wr_accept;
    logic                w_tx_ready;
    logic [7:0]          fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                w_unused_wdata_hi;

    assign w_unused_wdata_hi = &{1'b0, wdata[15:8]};

    assign w_tx_ready  = (tx_state_q == TX_IDLE);
    assign w_pop       = cs & re & ~addr & ~fifo_empty;
    assign w_stat_rd   = cs & re & addr;
    assign w_wr_accept = cs & we & ~addr & w_tx_ready;
    assign w_rx_fall   = rx_prev_q & ~rx_sync_q;
    assign w_ovr_set   = w_rx_push & fifo_full & ~w_pop;
    assign txd         = txd_q;

    uart_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_pop),
        .din   (rx_shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- receive FSM ----------------
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        w_rx_push   = 1'b0;
        w_frame_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = c_HALF_BIT;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    // Line back high at mid start bit: treat as a glitch
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = c_FULL_BIT;
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - c_CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = c_FULL_BIT;
                    if (rx_bit_q == c_LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + c_BIT_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - c_CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d  = RX_IDLE;
                    w_rx_push   = rx_sync_q;
                    w_frame_set = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - c_CNT_ONE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- transmit FSM ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (w_wr_accept) begin
                    tx_state_d = TX_START;
                    tx_shift_d = wdata[7:0];
                    tx_cnt_d   = c_FULL_BIT;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_cnt_d   = c_FULL_BIT;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q - c_CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = c_FULL_BIT;
                    if (tx_bit_q == c_LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + c_BIT_ONE;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - c_CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - c_CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // ---------------- sticky flags: a new error beats a clearing read ----------------
    always_comb begin
        overrun_d   = (overrun_q   & ~w_stat_rd) | w_ovr_set;
        frame_err_d = (frame_err_q & ~w_stat_rd) | w_frame_set;
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        if (addr) begin
            rdata[c_STAT_TX_READY]           = w_tx_ready;
            rdata[c_STAT_RX_AVAIL]           = ~fifo_empty;
            rdata[c_STAT_OVERRUN]            = overrun_q;
            rdata[c_STAT_FRAME_ERR]          = frame_err_q;
            rdata[c_STAT_COUNT_LSB +: 3]     = 3'(fifo_count);
        end else if (!fifo_empty) begin
            rdata[7:0] = fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rxd;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ctrl
// Description : Self-checking bench for uart_ctrl. Received bytes are tracked
//               in a scoreboard queue modelling the 4-entry FIFO; transmitted
//               bytes are queued on write and compared against the decoded
//               txd frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

    localparam int DIV = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        rxd   = 1'b1;
    logic        cs    = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic        addr  = 1'b1;
    logic [15:0] wdata = 16'h0000;
    logic        txd;
    logic [15:0] rdata;

    int          n_vec = 0;
    int          n_err = 0;

    logic [7:0]  sb_rx[$];
    logic [7:0]  sb_tx[$];
    logic        exp_ovr = 1'b0;
    logic        exp_fe  = 1'b0;

    uart_ctrl #(
        .DIV        (DIV),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .txd   (txd),
        .cs    (cs),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus and model only) ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic a, input logic [15:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        cyc(1);
        cs = 1'b0; we = 1'b0; addr = 1'b1; wdata = 16'h0000;
    endtask

    task automatic bus_read(input logic a, output logic [15:0] d);
        cs = 1'b1; re = 1'b1; addr = a;
        #1 d = rdata;
        cyc(1);
        cs = 1'b0; re = 1'b0; addr = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(DIV);
        end
        rxd = stop_bit;
        cyc(DIV);
        rxd = 1'b1;
    endtask

    task automatic tx_capture(output logic [9:0] frame);
        cyc(DIV / 2);
        frame[0] = txd;
        for (int i = 1; i < 10; i++) begin
            cyc(DIV);
            frame[i] = txd;
        end
    endtask

    function automatic void rx_model(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) begin
            exp_fe = 1'b1;
        end else if (sb_rx.size() < 4) begin
            sb_rx.push_back(b);
        end else begin
            exp_ovr = 1'b1;
        end
    endfunction

    function automatic logic [15:0] exp_status();
        logic [2:0] n;
        n = 3'(sb_rx.size());
        return {9'd0, n, exp_fe, exp_ovr, (n != 3'd0), 1'b1};
    endfunction

    function automatic logic [15:0] exp_data();
        logic [15:0] e;
        e = 16'h0000;
        if (sb_rx.size() != 0) begin
            e = {8'h00, sb_rx.pop_front()};
        end
        return e;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL reset_txd: got %b want 1", txd);
        end
        n_vec++;
        if (rdata !== 16'h0001) begin
            n_err++; $display("FAIL reset_status_in_reset: got %h want 0001", rdata);
        end
        rst = 1'b0;
        cyc(2);
        n_vec++;
        if (rdata !== exp_status()) begin
            n_err++; $display("FAIL reset_status: got %h want %h", rdata, exp_status());
        end
        addr = 1'b0;
        #1;
        n_vec++;
        if (rdata !== 16'h0000) begin
            n_err++; $display("FAIL reset_data: got %h want 0000", rdata);
        end
        addr = 1'b1;
        cyc(1);
    endtask

    task automatic test_tx_single();
        logic [9:0] frame;
        logic [9:0] exp_frame;
        int         low;
        low = 0;
        frame = '0;
        sb_tx.push_back(8'hA5);
        bus_write(1'b0, 16'h00A5);
        for (int c = 0; c <= 11 * DIV; c++) begin
            if (c == 3 * DIV + 1) begin
                cs = 1'b0; we = 1'b0; addr = 1'b1; wdata = 16'h0000;
                #1;
            end
            if (rdata[0] === 1'b0) low++;
            if (c < 10 * DIV && (c % DIV) == DIV / 2) frame[c / DIV] = txd;
            if (c == 3 * DIV) begin
                // write while busy: must be ignored
                cs = 1'b1; we = 1'b1; addr = 1'b0; wdata = 16'h00FF;
            end
            if (c < 11 * DIV) cyc(1);
        end
        exp_frame = {1'b1, sb_tx.pop_front(), 1'b0};
        n_vec++;
        if (frame !== exp_frame) begin
            n_err++; $display("FAIL tx_frame: got %b want %b", frame, exp_frame);
        end
        n_vec++;
        if (low != 10 * DIV) begin
            n_err++; $display("FAIL tx_busy_cycles: got %0d want %0d", low, 10 * DIV);
        end
        n_vec++;
        if (txd !== 1'b1 || rdata !== 16'h0001) begin
            n_err++; $display("FAIL tx_idle_after: txd %b status %h want 1 0001", txd, rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] f1, f2, e1, e2;
        int         waitc;
        sb_tx.push_back(8'h3C);
        bus_write(1'b0, 16'h003C);
        tx_capture(f1);
        waitc = 0;
        while (rdata[0] !== 1'b1 && waitc < 2 * DIV) begin
            cyc(1);
            waitc++;
        end
        n_vec++;
        if (waitc != DIV / 2) begin
            n_err++; $display("FAIL b2b_ready_delay: got %0d want %0d", waitc, DIV / 2);
        end
        sb_tx.push_back(8'hC3);
        bus_write(1'b0, 16'h00C3);
        n_vec++;
        if (txd !== 1'b0) begin
            n_err++; $display("FAIL b2b_start: txd got %b want 0", txd);
        end
        tx_capture(f2);
        e1 = {1'b1, sb_tx.pop_front(), 1'b0};
        e2 = {1'b1, sb_tx.pop_front(), 1'b0};
        n_vec++;
        if (f1 !== e1) begin
            n_err++; $display("FAIL b2b_frame1: got %b want %b", f1, e1);
        end
        n_vec++;
        if (f2 !== e2) begin
            n_err++; $display("FAIL b2b_frame2: got %b want %b", f2, e2);
        end
        cyc(DIV);
    endtask

    task automatic test_rx_byte();
        logic [15:0] d, e;
        send_rx(8'h3C, 1'b1);
        rx_model(8'h3C, 1'b1);
        cyc(4);
        e = exp_status();
        bus_read(1'b1, d);
        exp_ovr = 1'b0; exp_fe = 1'b0;
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL rx_status: got %h want %h", d, e);
        end
        e = exp_data();
        bus_read(1'b0, d);
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL rx_data: got %h want %h", d, e);
        end
        e = exp_status();
        bus_read(1'b1, d);
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL rx_status_after: got %h want %h", d, e);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] d, e;
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i), 1'b1);
            rx_model(8'(i), 1'b1);
        end
        cyc(4);
        for (int k = 0; k < 2; k++) begin
            e = exp_status();
            bus_read(1'b1, d);
            exp_ovr = 1'b0; exp_fe = 1'b0;
            n_vec++;
            if (d !== e) begin
                n_err++; $display("FAIL ovr_status%0d: got %h want %h", k, d, e);
            end
        end
        for (int i = 0; i < 5; i++) begin
            e = exp_data();
            bus_read(1'b0, d);
            n_vec++;
            if (d !== e) begin
                n_err++; $display("FAIL ovr_data%0d: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_frame_glitch();
        logic [15:0] d, e;
        send_rx(8'h55, 1'b0);
        rx_model(8'h55, 1'b0);
        cyc(DIV);
        e = exp_status();
        bus_read(1'b1, d);
        exp_ovr = 1'b0; exp_fe = 1'b0;
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL frame_status: got %h want %h", d, e);
        end
        rxd = 1'b0;
        cyc(DIV / 4);
        rxd = 1'b1;
        cyc(2 * DIV);
        e = exp_status();
        bus_read(1'b1, d);
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL glitch_status: got %h want %h", d, e);
        end
        send_rx(8'h81, 1'b1);
        rx_model(8'h81, 1'b1);
        cyc(4);
        e = exp_data();
        bus_read(1'b0, d);
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL glitch_next_data: got %h want %h", d, e);
        end
    endtask

    task automatic test_collision();
        logic [15:0] d, e, dc, ec;
        for (int i = 0; i < 4; i++) begin
            send_rx(8'hA0 + 8'(i), 1'b1);
            rx_model(8'hA0 + 8'(i), 1'b1);
        end
        fork
            send_rx(8'hA4, 1'b1);
            begin
                // land the pop on the stop-sample edge of the fifth byte
                cyc(2 + DIV / 2 + 9 * DIV);
                ec = exp_data();
                bus_read(1'b0, dc);
            end
        join
        n_vec++;
        if (dc !== ec) begin
            n_err++; $display("FAIL coll_pop_data: got %h want %h", dc, ec);
        end
        rx_model(8'hA4, 1'b1);
        cyc(4);
        e = exp_status();
        bus_read(1'b1, d);
        exp_ovr = 1'b0; exp_fe = 1'b0;
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL coll_status: got %h want %h", d, e);
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_data();
            bus_read(1'b0, d);
            n_vec++;
            if (d !== e) begin
                n_err++; $display("FAIL coll_drain%0d: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, e;
        logic [9:0]  f, ef;
        fork
            send_rx(8'hE5, 1'b1);
            begin
                cyc(2 * DIV);
                bus_write(1'b0, 16'h0030);
                cyc(4 * DIV + DIV / 2);
                n_vec++;
                if (txd !== 1'b0) begin
                    n_err++; $display("FAIL mid_txd_bit3: got %b want 0", txd);
                end
                #3 rst = 1'b1;
                #1;
                n_vec++;
                if (txd !== 1'b1) begin
                    n_err++; $display("FAIL mid_reset_txd: got %b want 1", txd);
                end
                n_vec++;
                if (rdata !== 16'h0001) begin
                    n_err++; $display("FAIL mid_reset_status: got %h want 0001", rdata);
                end
                #2 rst = 1'b0;
            end
        join
        sb_rx.delete();
        sb_tx.delete();
        exp_ovr = 1'b0; exp_fe = 1'b0;
        cyc(DIV);
        e = exp_status();
        bus_read(1'b1, d);
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL post_reset_status: got %h want %h", d, e);
        end
        sb_tx.push_back(8'h5A);
        bus_write(1'b0, 16'h005A);
        tx_capture(f);
        ef = {1'b1, sb_tx.pop_front(), 1'b0};
        n_vec++;
        if (f !== ef) begin
            n_err++; $display("FAIL post_reset_tx: got %b want %b", f, ef);
        end
        cyc(DIV);
        send_rx(8'h96, 1'b1);
        rx_model(8'h96, 1'b1);
        cyc(4);
        e = exp_data();
        bus_read(1'b0, d);
        n_vec++;
        if (d !== e) begin
            n_err++; $display("FAIL post_reset_rx: got %h want %h", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_byte();
        test_overrun();
        test_frame_glitch();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
